dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Word-organised data-memory target: the responder end of the core's load/store request interface.
//  Accepts one load/store request at a time over a valid/ready handshake.
//  Applies byte-lane placement for STORE_BYTE/STORE_HALFWORD/STORE_WORD and inserts a programmable number of wait states.
//  Returns an acknowledge/read-data response over a second valid/ready handshake. Sits between the MEM stage and on-chip SRAM.
// PARAMETERS
//  DEPTH_WORDS  1024  memory size in 32-bit words; ADDR_W = $clog2(DEPTH_WORDS)
//  WAIT_CYCLES  1     wait states between accept and access (0..15)
// PORTS
//  clk         in   1   clock, all state updates on posedge
//  reset       in   1   asynchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept a request (== state IDLE)
//  req_we      in   1   1 = store, 0 = load
//  req_addr    in   32  byte address
//  req_size    in   2   0 = byte, 1 = halfword, 2 = word (store_t encoding), 3 = illegal
//  req_wdata   in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  resp_valid  out  1   response present
//  resp_ready  in   1   requester accepts response
//  resp_rdata  out  32  load: aligned word at addr[31:2]; store/error: 0
//  resp_err    out  1   request rejected (misaligned / out of range / size 3)
// BEHAVIOUR
//  Reset values (async, while reset=1): state IDLE, wait counter 0.
//   Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
//   Memory array is NOT reset.
//  Request capture:
//   req_valid & req_ready at edge T latches we, addr, size, wdata into holding regs.
//   Inputs are ignored in all other cycles.
//  Error check at capture; any of the following sets err:
//   - size==3
//   - size==1 & addr[0]
//   - size==2 & addr[1:0]!=0
//   - addr[31:2] >= DEPTH_WORDS
//  FSM states IDLE, WAIT, ACCESS, RESP:
//   IDLE -> WAIT on handshake when WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1).
//   IDLE -> ACCESS on handshake when WAIT_CYCLES==0.
//   Error requests still traverse WAIT so error latency equals normal latency.
//   WAIT: counter decrements each cycle; at 0 -> ACCESS.
//   ACCESS (1 cycle): perform SRAM op, register resp_rdata/resp_err -> RESP.
//   RESP: resp_valid=1; rdata/err held stable until resp_valid & resp_ready; then -> IDLE.
//  Latency: accept at edge T -> resp_valid high after edge T+1+WAIT_CYCLES.
//   No back-to-back acceptance: req_ready returns the cycle after the response handshake.
//  Store lane placement (word index addr[ADDR_W+1:2]):
//   - byte: wdata[7:0] -> lane addr[1:0]
//   - half: wdata[15:0] -> lanes {addr[1],0},{addr[1],1}
//   - word: all 4 lanes
//   Unselected lanes unchanged.
//  Errored store: writes nothing. Errored load: rdata=0.
//  Load returns the full aligned word; sign/zero extension and lane select are done by the core.
//  Reset mid-operation:
//   - in WAIT: the pending store is dropped, memory unchanged.
//   - in RESP: the response is lost, resp_valid drops immediately (async).
//  resp_ready high while not in RESP has no effect.
//   req_valid held during RESP is not accepted until back in IDLE.
// TESTING
//  1 WAIT_CYCLES=1: store word 0xDEADBEEF @0x10, load @0x10.
//   -> resp_valid 3 cycles after each accept; load rdata=0xDEADBEEF, err=0.
//  2 Store byte 0xAA @0x11, then half 0x1234 @0x12 over word 0x00000000 @0x10; load @0x10 -> rdata=0x1234AA00.
//  3 Misaligned: half @0x13, word @0x22, size=3 @0x20.
//   -> err=1, rdata=0, memory @0x10/0x20 unchanged on readback.
//  4 Out of range: load @ (DEPTH_WORDS*4) -> err=1. Load @ (DEPTH_WORDS*4-4) -> err=0.
//  5 Back-pressure: resp_ready low 5 cycles in RESP.
//   -> resp_valid/rdata stable, req_ready=0, second req_valid not accepted until 1 cycle after handshake.
//  6 Reset asserted in WAIT of store 0x55 @0x30.
//   -> outputs at reset values, later load @0x30 returns prior contents. Repeat with WAIT_CYCLES=0: latency 2.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the MEM stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data-memory responder: one request at a time, programmable wait
// states, byte-lane stores, full-word loads, error response for illegal accesses.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset,
    dmem_responder_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [3:0]         cnt_r;
    logic [3:0]         cnt_s;
    logic               we_r;
    logic [ADDR_W-1:0]  idx_r;
    logic [1:0]         off_r;
    logic [1:0]         size_r;
    logic [31:0]        wdata_r;
    logic               err_r;
    logic [31:0]        rdata_r;
    logic               resp_err_r;
    logic               accept_s;
    logic [3:0]         wmask_s;
    logic [31:0]        wlane_s;
    logic [31:0]        mem [DEPTH_WORDS];

    function automatic logic req_error(input logic [31:0] addr, input logic [1:0] size);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = addr[0];
            2'd2:    bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        req_error = bad || ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    lane_mask = 4'b0001 << off;
            2'd1:    lane_mask = off[1] ? 4'b1100 : 4'b0011;
            2'd2:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Replicating the right-justified data lets the lane mask alone pick the bytes.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'd0:    lane_data = {4{wdata[7:0]}};
            2'd1:    lane_data = {2{wdata[15:0]}};
            default: lane_data = wdata;
        endcase
    endfunction

    assign accept_s = bus.req_valid && (state_r == ST_IDLE);
    assign wmask_s  = lane_mask(size_r, off_r);
    assign wlane_s  = lane_data(size_r, wdata_r);

    assign bus.req_ready  = (state_r == ST_IDLE);
    assign bus.resp_valid = (state_r == ST_RESP);
    assign bus.resp_rdata = rdata_r;
    assign bus.resp_err   = resp_err_r;

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic; errored requests follow the same path so latency never leaks the error.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (WAIT_CYCLES > 0) begin
                        state_s = ST_WAIT;
                        cnt_s   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_s = ST_ACCESS;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_ACCESS;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_ACCESS: state_s = ST_RESP;
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Request holding registers, loaded only on the request handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_r    <= 1'b0;
            idx_r   <= '0;
            off_r   <= 2'b00;
            size_r  <= 2'b00;
            wdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
        end else if (accept_s) begin
            we_r    <= bus.req_we;
            idx_r   <= bus.req_addr[ADDR_W+1:2];
            off_r   <= bus.req_addr[1:0];
            size_r  <= bus.req_size;
            wdata_r <= bus.req_wdata;
            err_r   <= req_error(bus.req_addr, bus.req_size);
        end
    end

    // SRAM array; writes happen only in ACCESS, so a reset during WAIT drops the store.
    always_ff @(posedge clk) begin
        if (state_r == ST_ACCESS && we_r && !err_r) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_s[i]) begin
                    mem[idx_r][8*i +: 8] <= wlane_s[8*i +: 8];
                end
            end
        end
    end

    // Response registers, held stable through RESP until the handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_r    <= 32'h0000_0000;
            resp_err_r <= 1'b0;
        end else if (state_r == ST_ACCESS) begin
            resp_err_r <= err_r;
            rdata_r    <= (!we_r && !err_r) ? mem[idx_r] : 32'h0000_0000;
        end else if (state_r == ST_RESP && bus.resp_ready) begin
            resp_err_r <= 1'b0;
            rdata_r    <= 32'h0000_0000;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state, one with none.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_ready = 1'b0;
    int          n_assert = 0;
    int          n_fail = 0;

    dmem_responder_if bus1 ();
    dmem_responder_if bus0 ();

    assign bus1.req_valid  = req_valid && sel;
    assign bus0.req_valid  = req_valid && !sel;
    assign bus1.resp_ready = resp_ready && sel;
    assign bus0.resp_ready = resp_ready && !sel;
    assign bus1.req_we     = req_we;
    assign bus0.req_we     = req_we;
    assign bus1.req_addr   = req_addr;
    assign bus0.req_addr   = req_addr;
    assign bus1.req_size   = req_size;
    assign bus0.req_size   = req_size;
    assign bus1.req_wdata  = req_wdata;
    assign bus0.req_wdata  = req_wdata;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

    always #5 clk = ~clk;

    wire        rv  = sel ? bus1.resp_valid : bus0.resp_valid;
    wire        rr  = sel ? bus1.req_ready  : bus0.req_ready;
    wire [31:0] rd  = sel ? bus1.resp_rdata : bus0.resp_rdata;
    wire        rer = sel ? bus1.resp_err   : bus0.resp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] wdata);
        @(negedge clk);
        req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
    endtask

    // Called just after the accepting edge; lat = negedges until resp_valid is seen.
    task automatic wait_resp(output logic [31:0] rdata, output logic err, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            if (lat == 0) req_valid = 1'b0;
            lat++;
        end while (!rv && lat < 40);
        rdata = rd;
        err   = rer;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] rdata;
        logic        err;
        int          lat;
        start_req(we, addr, size, wdata);
        wait_resp(rdata, err, lat);
        chk({tag, ":lat"}, 32'(lat), sel ? 32'd3 : 32'd2);
        chk({tag, ":rdata"}, rdata, exp_rdata);
        chk({tag, ":err"}, {31'd0, err}, {31'd0, exp_err});
        finish_resp();
    endtask

    initial begin
        logic [31:0] rdata;
        logic        err;
        int          lat;

        // Reset values on both instances.
        #2;
        chk("rst1:req_ready", {31'd0, bus1.req_ready}, 32'd1);
        chk("rst1:resp_valid", {31'd0, bus1.resp_valid}, 32'd0);
        chk("rst1:resp_rdata", bus1.resp_rdata, 32'h0);
        chk("rst1:resp_err", {31'd0, bus1.resp_err}, 32'd0);
        chk("rst0:req_ready", {31'd0, bus0.req_ready}, 32'd1);
        chk("rst0:resp_valid", {31'd0, bus0.resp_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Basic word store / load.
        do_req("t1_st", 1'b1, 32'h10, 2'd2, 32'hDEAD_BEEF, 32'h0, 1'b0);
        do_req("t1_ld", 1'b0, 32'h10, 2'd2, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Byte and halfword lane placement.
        do_req("t2_clr", 1'b1, 32'h10, 2'd2, 32'h0000_0000, 32'h0, 1'b0);
        do_req("t2_sb", 1'b1, 32'h11, 2'd0, 32'hFFFF_FFAA, 32'h0, 1'b0);
        do_req("t2_ld1", 1'b0, 32'h10, 2'd2, 32'h0, 32'h0000_AA00, 1'b0);
        do_req("t2_sh", 1'b1, 32'h12, 2'd1, 32'hFFFF_1234, 32'h0, 1'b0);
        do_req("t2_ld2", 1'b0, 32'h10, 2'd2, 32'h0, 32'h1234_AA00, 1'b0);

        // Misaligned and illegal-size requests.
        do_req("t3_init", 1'b1, 32'h20, 2'd2, 32'h1122_3344, 32'h0, 1'b0);
        do_req("t3_sh13", 1'b1, 32'h13, 2'd1, 32'h0000_FFFF, 32'h0, 1'b1);
        do_req("t3_sw22", 1'b1, 32'h22, 2'd2, 32'hFFFF_FFFF, 32'h0, 1'b1);
        do_req("t3_sz3", 1'b1, 32'h20, 2'd3, 32'hFFFF_FFFF, 32'h0, 1'b1);
        do_req("t3_lh13", 1'b0, 32'h13, 2'd1, 32'h0, 32'h0, 1'b1);
        do_req("t3_rb10", 1'b0, 32'h10, 2'd2, 32'h0, 32'h1234_AA00, 1'b0);
        do_req("t3_rb20", 1'b0, 32'h20, 2'd2, 32'h0, 32'h1122_3344, 1'b0);

        // Address range boundary.
        do_req("t4_oor", 1'b0, 32'h1000, 2'd2, 32'h0, 32'h0, 1'b1);
        do_req("t4_lst_st", 1'b1, 32'hFFC, 2'd2, 32'hCAFE_F00D, 32'h0, 1'b0);
        do_req("t4_lst_ld", 1'b0, 32'hFFC, 2'd2, 32'h0, 32'hCAFE_F00D, 1'b0);

        // Back-pressure with a second request waiting.
        do_req("t5_st", 1'b1, 32'h40, 2'd2, 32'hA5A5_A5A5, 32'h0, 1'b0);
        start_req(1'b0, 32'h40, 2'd2, 32'h0);
        wait_resp(rdata, err, lat);
        chk("t5:lat", 32'(lat), 32'd3);
        req_addr  = 32'h10;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5:hold_valid", {31'd0, rv}, 32'd1);
            chk("t5:hold_rdata", rd, 32'hA5A5_A5A5);
            chk("t5:hold_ready", {31'd0, rr}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("t5:ready_after", {31'd0, rr}, 32'd1);
        chk("t5:valid_after", {31'd0, rv}, 32'd0);
        @(posedge clk);
        wait_resp(rdata, err, lat);
        chk("t5:lat2", 32'(lat), 32'd3);
        chk("t5:rdata2", rdata, 32'h1234_AA00);
        finish_resp();

        // Reset in WAIT drops a pending store.
        do_req("t6_init", 1'b1, 32'h30, 2'd2, 32'h0BAD_F00D, 32'h0, 1'b0);
        start_req(1'b1, 32'h30, 2'd2, 32'h0000_0055);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6:rst_ready", {31'd0, rr}, 32'd1);
        chk("t6:rst_valid", {31'd0, rv}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_req("t6_rb", 1'b0, 32'h30, 2'd2, 32'h0, 32'h0BAD_F00D, 1'b0);

        // Reset in RESP drops the response at once.
        start_req(1'b0, 32'h30, 2'd2, 32'h0);
        wait_resp(rdata, err, lat);
        chk("t6r:valid_pre", {31'd0, rv}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t6r:valid_rst", {31'd0, rv}, 32'd0);
        chk("t6r:rdata_rst", rd, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Zero wait states.
        sel = 1'b0;
        do_req("t6z_init", 1'b1, 32'h30, 2'd2, 32'h0BAD_F00D, 32'h0, 1'b0);
        start_req(1'b1, 32'h30, 2'd2, 32'h0000_0055);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6z:rst_valid", {31'd0, rv}, 32'd0);
        chk("t6z:rst_ready", {31'd0, rr}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        do_req("t6z_rb", 1'b0, 32'h30, 2'd2, 32'h0, 32'h0BAD_F00D, 1'b0);
        do_req("t6z_oor", 1'b0, 32'h1000, 2'd2, 32'h0, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
